matmul_ctrl: RTL and testbench

MATMUL_CTRL -- requirements
Module: matmul_ctrl

---
 rtl/matmul_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_matmul_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl.sv
// Sequential matrix-multiply controller: reads shape/base parameters and byte
// operands from a single-port data memory, accumulates dot products, and writes 16-bit results.
module matmul_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    PARAM = 4'd1,
    CLR   = 4'd2,
    RD_A  = 4'd3,
    CAP_A = 4'd4,
    RD_B  = 4'd5,
    CAP_B = 4'd6,
    WR    = 4'd7,
    FIN   = 4'd8
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [3:0]              pcnt_r, pcnt_nxt_s;
  logic [DATA_WIDTH-1:0]   m_r, m_nxt_s;
  logic [DATA_WIDTH-1:0]   n_r, n_nxt_s;
  logic [DATA_WIDTH-1:0]   l_r, l_nxt_s;
  logic [ADDR_WIDTH-1:0]   a_base_r, a_base_nxt_s;
  logic [ADDR_WIDTH-1:0]   c_base_r, c_base_nxt_s;
  logic [ADDR_WIDTH-1:0]   b_base_s;
  logic [DATA_WIDTH-1:0]   i_r, i_nxt_s;
  logic [DATA_WIDTH-1:0]   j_r, j_nxt_s;
  logic [DATA_WIDTH-1:0]   k_r, k_nxt_s;
  logic [DATA_WIDTH:0]     i_inc_s, j_inc_s, k_inc_s;
  logic [DATA_WIDTH-1:0]   a_byte_r, a_byte_nxt_s;
  logic [ACC_W-1:0]        acc_r, acc_nxt_s;
  logic [ACC_W-1:0]        prod_s;
  logic                    busy_r, done_r, we_r;
  logic [ADDR_WIDTH-1:0]   r_addr_r, r_addr_nxt_s;
  logic [ADDR_WIDTH-1:0]   w_addr_r, w_addr_nxt_s;
  logic [ACC_W-1:0]        w_data_r, w_data_nxt_s;

  // Fixed parameter-block addresses, fetched in this order: m, n, l, A base, C base.
  function automatic logic [ADDR_WIDTH-1:0] param_addr(input logic [2:0] idx);
    logic [7:0] a;
    case (idx)
      3'd0:    a = 8'd0;
      3'd1:    a = 8'd2;
      3'd2:    a = 8'd4;
      3'd3:    a = 8'd12;
      3'd4:    a = 8'd14;
      default: a = 8'd0;
    endcase
    return ADDR_WIDTH'(a);
  endfunction

  // base + (row*stride + col), optionally doubled for 16-bit results; wraps at the address width.
  function automatic logic [ADDR_WIDTH-1:0] addr_calc(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] row,
    input logic [DATA_WIDTH-1:0] stride,
    input logic [DATA_WIDTH-1:0] col,
    input logic                  dbl
  );
    logic [31:0] off;
    logic [31:0] off2;
    off  = 32'(row) * 32'(stride) + 32'(col);
    off2 = dbl ? {off[30:0], 1'b0} : off;
    return base + off2[ADDR_WIDTH-1:0];
  endfunction

  assign b_base_s = addr_calc(a_base_r, m_r, n_r, {DATA_WIDTH{1'b0}}, 1'b0);
  assign prod_s   = ACC_W'(a_byte_r) * ACC_W'(mem_r_data);
  assign i_inc_s  = {1'b0, i_r} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign j_inc_s  = {1'b0, j_r} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign k_inc_s  = {1'b0, k_r} + {{DATA_WIDTH{1'b0}}, 1'b1};

  // Next-state, loop-counter and output-register computation.
  always_comb begin
    state_nxt_s  = state_r;
    pcnt_nxt_s   = pcnt_r;
    m_nxt_s      = m_r;
    n_nxt_s      = n_r;
    l_nxt_s      = l_r;
    a_base_nxt_s = a_base_r;
    c_base_nxt_s = c_base_r;
    i_nxt_s      = i_r;
    j_nxt_s      = j_r;
    k_nxt_s      = k_r;
    a_byte_nxt_s = a_byte_r;
    acc_nxt_s    = acc_r;
    r_addr_nxt_s = r_addr_r;
    w_addr_nxt_s = w_addr_r;
    w_data_nxt_s = w_data_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s  = PARAM;
          pcnt_nxt_s   = 4'd0;
          r_addr_nxt_s = param_addr(3'd0);
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      PARAM: begin
        // Odd sub-cycles capture the byte requested in the preceding even sub-cycle.
        if (pcnt_r[0]) begin
          case (pcnt_r[3:1])
            3'd0:    m_nxt_s      = mem_r_data;
            3'd1:    n_nxt_s      = mem_r_data;
            3'd2:    l_nxt_s      = mem_r_data;
            3'd3:    a_base_nxt_s = ADDR_WIDTH'(mem_r_data);
            3'd4:    c_base_nxt_s = ADDR_WIDTH'(mem_r_data);
            default: m_nxt_s      = m_r;
          endcase
        end else begin
          m_nxt_s = m_r;
        end
        if (pcnt_r == 4'd9) begin
          i_nxt_s = {DATA_WIDTH{1'b0}};
          j_nxt_s = {DATA_WIDTH{1'b0}};
          if ((m_r == '0) || (n_r == '0) || (l_r == '0)) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = CLR;
          end
        end else begin
          pcnt_nxt_s = pcnt_r + 4'd1;
          if (pcnt_r[0]) begin
            r_addr_nxt_s = param_addr(pcnt_r[3:1] + 3'd1);
          end else begin
            r_addr_nxt_s = r_addr_r;
          end
        end
      end
      CLR: begin
        acc_nxt_s    = {ACC_W{1'b0}};
        k_nxt_s      = {DATA_WIDTH{1'b0}};
        r_addr_nxt_s = addr_calc(a_base_r, i_r, n_r, {DATA_WIDTH{1'b0}}, 1'b0);
        state_nxt_s  = RD_A;
      end
      RD_A: begin
        state_nxt_s = CAP_A;
      end
      CAP_A: begin
        a_byte_nxt_s = mem_r_data;
        r_addr_nxt_s = addr_calc(b_base_s, k_r, l_r, j_r, 1'b0);
        state_nxt_s  = RD_B;
      end
      RD_B: begin
        state_nxt_s = CAP_B;
      end
      CAP_B: begin
        acc_nxt_s = acc_r + prod_s;
        if (k_inc_s < {1'b0, n_r}) begin
          k_nxt_s      = k_inc_s[DATA_WIDTH-1:0];
          r_addr_nxt_s = addr_calc(a_base_r, i_r, n_r, k_inc_s[DATA_WIDTH-1:0], 1'b0);
          state_nxt_s  = RD_A;
        end else begin
          w_addr_nxt_s = addr_calc(c_base_r, i_r, l_r, j_r, 1'b1);
          w_data_nxt_s = acc_r + prod_s;
          state_nxt_s  = WR;
        end
      end
      WR: begin
        if (j_inc_s < {1'b0, l_r}) begin
          j_nxt_s     = j_inc_s[DATA_WIDTH-1:0];
          state_nxt_s = CLR;
        end else begin
          j_nxt_s = {DATA_WIDTH{1'b0}};
          if (i_inc_s < {1'b0, m_r}) begin
            i_nxt_s     = i_inc_s[DATA_WIDTH-1:0];
            state_nxt_s = CLR;
          end else begin
            state_nxt_s = FIN;
          end
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pcnt_r   <= 4'd0;
      m_r      <= {DATA_WIDTH{1'b0}};
      n_r      <= {DATA_WIDTH{1'b0}};
      l_r      <= {DATA_WIDTH{1'b0}};
      a_base_r <= {ADDR_WIDTH{1'b0}};
      c_base_r <= {ADDR_WIDTH{1'b0}};
      i_r      <= {DATA_WIDTH{1'b0}};
      j_r      <= {DATA_WIDTH{1'b0}};
      k_r      <= {DATA_WIDTH{1'b0}};
      a_byte_r <= {DATA_WIDTH{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      we_r     <= 1'b0;
      r_addr_r <= {ADDR_WIDTH{1'b0}};
      w_addr_r <= {ADDR_WIDTH{1'b0}};
      w_data_r <= {ACC_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      pcnt_r   <= pcnt_nxt_s;
      m_r      <= m_nxt_s;
      n_r      <= n_nxt_s;
      l_r      <= l_nxt_s;
      a_base_r <= a_base_nxt_s;
      c_base_r <= c_base_nxt_s;
      i_r      <= i_nxt_s;
      j_r      <= j_nxt_s;
      k_r      <= k_nxt_s;
      a_byte_r <= a_byte_nxt_s;
      acc_r    <= acc_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      done_r   <= (state_nxt_s == FIN);
      we_r     <= (state_nxt_s == WR);
      r_addr_r <= r_addr_nxt_s;
      w_addr_r <= w_addr_nxt_s;
      w_data_r <= w_data_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign mem_we     = we_r;
  assign mem_r_addr = r_addr_r;
  assign mem_w_addr = w_addr_r;
  assign mem_w_data = w_data_r;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: behavioural memory, arithmetic reference
// model of C = A x B, directed corner cases plus randomized shapes and contents.
module tb_matmul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, mem_we;
  logic [7:0]  mem_r_addr, mem_w_addr, rdata;
  logic [15:0] mem_w_data;

  logic [7:0]  mem     [256];
  logic [7:0]  img     [256];
  logic [7:0]  exp_img [256];
  logic        load_en = 1'b0;
  logic [23:0] wq[$];
  logic [23:0] exp_q[$];
  int          exp_cyc;
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  matmul_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (rdata),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, two-byte write, bulk load from img.
  always @(posedge clk) begin
    if (load_en) begin
      mem <= img;
    end else if (mem_we) begin
      mem[mem_w_addr]                <= mem_w_data[7:0];
      mem[8'(mem_w_addr + 8'd1)]     <= mem_w_data[15:8];
    end else begin
      rdata <= mem[mem_r_addr];
    end
  end

  // Record every write that actually lands and every done pulse.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) wq.push_back({mem_w_addr, mem_w_data});
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C computed element by element over a copy of the memory image.
  task automatic model();
    logic [7:0] r [256];
    int m, n, l, ab, cb, bb, sum, wa;
    r  = img;
    m  = int'(r[0]); n = int'(r[2]); l = int'(r[4]);
    ab = int'(r[12]); cb = int'(r[14]);
    bb = ab + m * n;
    exp_q.delete();
    if (m == 0 || n == 0 || l == 0) begin
      exp_cyc = 10;
    end else begin
      exp_cyc = 10 + m * l * (4 * n + 2);
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < l; j++) begin
          sum = 0;
          for (int k = 0; k < n; k++)
            sum += int'(r[8'(ab + i * n + k)]) * int'(r[8'(bb + k * l + j)]);
          wa = cb + 2 * (i * l + j);
          exp_q.push_back({8'(wa), 16'(sum)});
          r[8'(wa)]     = 8'(sum);
          r[8'(wa + 1)] = 8'(sum >> 8);
        end
      end
    end
    exp_img = r;
  endtask

  task automatic set_default();
    foreach (img[a]) img[a] = 8'($urandom_range(0, 255));
    img[0] = 8'd5; img[2] = 8'd3; img[4] = 8'd4; img[12] = 8'd15; img[14] = 8'd70;
  endtask

  task automatic load_mem();
    @(negedge clk); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  task automatic run_op(input int poke);
    int cyc, d0, bad, nw;
    bit busy_ok;
    load_mem();
    wq.delete();
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); cyc++;
      @(negedge clk);
      start = (cyc == poke);
    end
    start = 1'b0;
    chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    chk("busy_during_op", 32'(busy_ok && busy === 1'b1), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_fin", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("write_count", 32'(wq.size()), 32'(exp_q.size()));
    nw = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int e = 0; e < nw; e++) begin
      chk("wr_addr", 32'(wq[e][23:16]), 32'(exp_q[e][23:16]));
      chk("wr_data", 32'(wq[e][15:0]), 32'(exp_q[e][15:0]));
    end
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_img[a]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_raddr", 32'(mem_r_addr), 32'd0);
    chk("rst_waddr", 32'(mem_w_addr), 32'd0);
    chk("rst_wdata", 32'(mem_w_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Default 5x3 * 3x4 problem.
    set_default(); model();
    chk("default_cyc_model", 32'(exp_cyc), 32'd290);
    run_op(-1);
    chk("default_writes", 32'(wq.size()), 32'd20);

    // Zero inner dimension: no writes, done after parameter fetch.
    set_default(); img[2] = 8'd0; model();
    run_op(-1);
    chk("zero_n_writes", 32'(wq.size()), 32'd0);

    // Largest product.
    set_default();
    img[0] = 8'd1; img[2] = 8'd1; img[4] = 8'd1; img[12] = 8'd20; img[14] = 8'd50;
    img[20] = 8'd255; img[21] = 8'd255;
    model();
    run_op(-1);
    chk("ff_data", 32'(wq[0][15:0]), 32'hFE01);
    chk("ff_addr", 32'(wq[0][23:16]), 32'd50);

    // Address wrap: A at 255, B wraps to address 0 (holds m=1), C at 255.
    set_default();
    img[0] = 8'd1; img[2] = 8'd1; img[4] = 8'd1; img[12] = 8'd255; img[14] = 8'd255;
    img[255] = 8'd7;
    model();
    run_op(-1);
    chk("wrap_addr", 32'(wq[0][23:16]), 32'd255);
    chk("wrap_data", 32'(wq[0][15:0]), 32'd7);

    // Start pulsed while busy is ignored.
    set_default(); model();
    run_op(5);

    // Randomized shapes, bases and contents.
    for (int t = 0; t < 6; t++) begin
      foreach (img[a]) img[a] = 8'($urandom_range(0, 255));
      img[0]  = 8'($urandom_range(0, 3));
      img[2]  = 8'($urandom_range(0, 3));
      img[4]  = 8'($urandom_range(0, 3));
      img[12] = 8'($urandom_range(16, 255));
      img[14] = 8'($urandom_range(16, 255));
      model();
      run_op(-1);
    end

    // Reset during the third write of the default run.
    set_default(); model();
    load_mem();
    wq.delete();
    start = 1'b1; @(posedge clk); @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(mem_we === 1'b1 && wq.size() == 2) && guard < 400) begin
      @(negedge clk); guard++;
    end
    chk("abort_reached", 32'(wq.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_raddr", 32'(mem_r_addr), 32'd0);
    chk("abort_waddr", 32'(mem_w_addr), 32'd0);
    chk("abort_wdata", 32'(mem_w_data), 32'd0);
    chk("abort_c00", 32'({mem[71], mem[70]}), 32'(exp_q[0][15:0]));
    chk("abort_c01", 32'({mem[73], mem[72]}), 32'(exp_q[1][15:0]));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_more_writes", 32'(wq.size()), 32'd2);
    chk("abort_idle", 32'(busy), 32'd0);
    run_op(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
